// File: rtl/serial_comparator_ctrl_if.sv
// rtl/serial_comparator_ctrl_if.sv - request/result bundle for the serial magnitude comparator
interface serial_comparator_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt, bit_cnt
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt, bit_cnt
    );
endinterface

// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - MSB-first bit-serial unsigned comparator with early exit
module comparator1bit (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);
    assign eq = ~(a ^ b);
    assign gt = a & ~b;
    assign lt = ~a & b;
endmodule

module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_comparator_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic             w_bit_a;
    logic             w_bit_b;
    logic             w_eq;
    logic             w_gt;
    logic             w_lt;

    // Only the shadow copies feed the comparator, so a/b may change freely during RUN.
    assign w_bit_a = r_a[r_idx];
    assign w_bit_b = r_b[r_idx];

    comparator1bit u_cmp (
        .a  (w_bit_a),
        .b  (w_bit_b),
        .eq (w_eq),
        .gt (w_gt),
        .lt (w_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= IDX_TOP;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_idx     <= IDX_TOP;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_eq      <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    // The first differing bit from the top decides the magnitude outright.
                    if (!w_eq) begin
                        r_gt    <= w_gt;
                        r_lt    <= w_lt;
                        r_eq    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_idx == '0) begin
                        r_eq    <= 1'b1;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.eq      = r_eq;
    assign bus.gt      = r_gt;
    assign bus.lt      = r_lt;
    assign bus.bit_cnt = r_bit_cnt;
endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// tb/tb_serial_comparator_ctrl.sv - directed and randomized bench for serial_comparator_ctrl
module tb_serial_comparator_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_comparator_ctrl_if #(.WIDTH(W)) bus ();

    serial_comparator_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges from accept to done: scan from the MSB for the first differing bit.
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = W - 1; i >= 0; i--)
            if (x[i] != y[i]) return W - i;
        return W;
    endfunction

    function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y);
        int ux;
        int uy;
        ux = int'(x);
        uy = int'(y);
        return {ux == uy, ux > uy, ux < uy};
    endfunction

    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input bit disturb, input logic [W-1:0] da, input logic [W-1:0] db);
        int n;
        int busy_n;
        int el;
        logic [2:0] er;
        el = exp_lat(ta, tb_v);
        er = exp_res(ta, tb_v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        chk("busy_after_accept", {31'd0, bus.busy}, 1);
        chk("result_cleared_on_accept", {29'd0, bus.eq, bus.gt, bus.lt}, 0);
        n = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && n < W + 4) begin
            if (bus.busy === 1'b1) busy_n++;
            if (disturb && n == 1) begin
                bus.start = 1'b1;
                bus.a     = da;
                bus.b     = db;
            end
            if (disturb && n == 2) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("done_seen", {31'd0, bus.done}, 1);
        chk("latency", n, el);
        chk("busy_cycles", busy_n, el);
        chk("busy_at_done", {31'd0, bus.busy}, 0);
        chk("result_eq_gt_lt", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, er});
        chk("bit_cnt_at_done", {29'd0, bus.bit_cnt}, el);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 0);
        chk("result_held", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, er});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;
        bit           seen;
        total = 0;
        bad   = 0;

        // Reset overrides a pending start.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_result", {29'd0, bus.eq, bus.gt, bus.lt}, 0);
        chk("rst_bit_cnt", {29'd0, bus.bit_cnt}, 0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {31'd0, bus.busy}, 0);

        run_cmp(8'hA5, 8'h25, 1'b0, 8'h00, 8'h00);
        run_cmp(8'h3C, 8'h3D, 1'b0, 8'h00, 8'h00);
        run_cmp(8'h5A, 8'h5A, 1'b0, 8'h00, 8'h00);
        run_cmp(8'h10, 8'h11, 1'b1, 8'hFF, 8'h00);
        run_cmp(8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        run_cmp(8'hFF, 8'hFE, 1'b0, 8'h00, 8'h00);
        run_cmp(8'h00, 8'h80, 1'b0, 8'h00, 8'h00);

        // Reset during the 4th RUN cycle of an equal-operand compare.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h5A;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_done", {31'd0, bus.done}, 0);
        chk("abort_result", {29'd0, bus.eq, bus.gt, bus.lt}, 0);
        chk("abort_bit_cnt", {29'd0, bus.bit_cnt}, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen}, 0);
        run_cmp(8'h01, 8'h00, 1'b0, 8'h00, 8'h00);

        // start held high: back-to-back compares with one IDLE cycle between them.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("held_done_%0d", k), {31'd0, bus.done}, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) chk($sformatf("held_gt_%0d", k), {31'd0, bus.gt}, 1);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("held_stop_idle", {31'd0, bus.busy}, 0);

        // Randomized compares, biased toward equal and near-equal operands.
        for (int t = 0; t < 40; t++) begin
            ra  = W'($urandom);
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      rb = ra;
            else if (sel == 1) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            else               rb = W'($urandom);
            run_cmp(ra, rb, ($urandom_range(0, 1) == 1), W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_comparator_ctrl.md
SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low, sampled on the clk rising edge.
REQ-004 The block SHALL have port start, input, 1 bit: compare request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, unsigned, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, unsigned, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result completion.
REQ-009 The block SHALL have port eq, output, 1 bit: registered result, A == B.
REQ-010 The block SHALL have port gt, output, 1 bit: registered result, A > B.
REQ-011 The block SHALL have port lt, output, 1 bit: registered result, A < B.
REQ-012 The block SHALL have port bit_cnt, output, clog2(WIDTH+1) bits: number of bit positions examined in the last or current comparison.

Function
REQ-013 The block SHALL instantiate exactly one comparator1bit (ports a, b, eq, gt, lt) and SHALL evaluate one operand bit pair per clock through it, MSB first; no other magnitude logic is permitted.
REQ-014 The FSM SHALL have two states, IDLE and RUN.
REQ-015 IDLE with start=1 SHALL latch a/b into shadow registers, set idx=WIDTH-1, set bit_cnt=0 and busy=1, clear eq/gt/lt, and move to RUN on the same edge.
REQ-016 RUN SHALL feed shadow bit idx of A and B to the comparator every cycle and increment bit_cnt on each edge.
REQ-017 RUN SHALL stop early: if the comparator reports gt or lt, the edge SHALL register that result, assert done, clear busy and return to IDLE.
REQ-018 RUN with comparator eq and idx==0 SHALL register eq=1, assert done, clear busy and return to IDLE.
REQ-019 RUN with comparator eq and idx>0 SHALL decrement idx and stay in RUN.
REQ-020 Latency from the start-accept edge to the done edge SHALL be WIDTH-i edges, where i is the highest differing bit index; for equal operands it SHALL be WIDTH edges. bit_cnt at done SHALL equal that latency.
REQ-021 Outside the completion cycle, done SHALL be 0. The done pulse SHALL last exactly one cycle.
REQ-022 eq, gt and lt SHALL be mutually exclusive at all times, and exactly one SHALL be high from done until the next accepted start.
REQ-023 start asserted while busy SHALL be ignored, with no queuing; changes on a/b during RUN SHALL NOT affect the result.
REQ-024 start held high continuously SHALL launch a new comparison on the first IDLE cycle after done, yielding back-to-back operations with one IDLE cycle between them.
REQ-025 With WIDTH=1, every comparison SHALL complete in 1 edge.

Reset
REQ-026 An edge with rst_n=0 SHALL force IDLE, busy=0, done=0, eq=gt=lt=0, bit_cnt=0, idx=WIDTH-1 and shadow registers to 0, overriding start.
REQ-027 Reset asserted mid-RUN SHALL abort the comparison with no done pulse. The first start after rst_n returns high SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 Scenario: a=8'hA5, b=8'h25, start pulse -> done 1 edge after accept; gt=1, eq=0, lt=0; bit_cnt=1.
REQ-029 Scenario: a=8'h3C, b=8'h3D -> done 8 edges after accept; lt=1, eq=0, gt=0; bit_cnt=8.
REQ-030 Scenario: a=b=8'h5A -> done 8 edges after accept; eq=1, eq=gt... gt=0, lt=0; busy high for exactly 8 cycles.
REQ-031 Scenario: start pulsed again and a/b changed to 8'hFF/8'h00 during a RUN of 8'h10 vs 8'h11 -> single done; result lt=1; the second start is ignored.
REQ-032 Scenario: rst_n=0 for one edge at the 4th RUN cycle of an equal-operand compare -> no done, all outputs 0; a next compare of 8'h01 vs 8'h00 gives gt=1, bit_cnt=8.
REQ-033 Scenario: start held high for 3 compares of 8'h80 vs 8'h00 -> three done pulses spaced 2 cycles apart, each with gt=1.
